// File: rtl/stage_2_pkg.sv
// Shared constants and helpers for the AV1 arithmetic encoder stage 2.
// Holds range reset value, minimum probability and the scaled product.
package stage_2_pkg;

  localparam int RANGE_W = 16;
  localparam int D_WIDTH = 5;

  localparam logic [RANGE_W-1:0] RANGE_RESET = 16'h8000;
  localparam logic [RANGE_W-1:0] EC_MIN_PROB = 16'd4;

  // (R8 * x) at 24 bits, then >> 1, kept modulo RANGE_W
  function automatic logic [RANGE_W-1:0] scale_prod(
    input logic [7:0]         r8,
    input logic [RANGE_W-1:0] x
  );
    logic [23:0] p;
    p = {16'b0, r8} * {8'b0, x};
    return p[RANGE_W:1];
  endfunction

endpackage

// File: rtl/stage_2_lzc.sv
// Combinational leading-zero counter used to normalise the range.
// An all-zero input reports a count of W.
module stage_2_lzc #(
  parameter int W  = 16,
  parameter int DW = 5
) (
  input  logic [W-1:0]  din,
  output logic [DW-1:0] cnt
);

  always_comb begin
    cnt = DW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = DW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/stage_2.sv
// AV1 arithmetic encoder stage 2: range update and normalisation.
// Results are registered behind a valid/ready handshake.
module stage_2
  import stage_2_pkg::*;
#(
  parameter int RANGE_WIDTH    = 16,
  parameter int SYMBOL_WIDTH   = 4,
  parameter int LUT_DATA_WIDTH = 16,
  parameter int D_WIDTH        = 5
) (
  input  logic                      clk_stage_2,
  input  logic                      reset_stage_2,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      COMP_mux_1,
  input  logic                      bool_n,
  input  logic [LUT_DATA_WIDTH-1:0] lut_u_in,
  input  logic [LUT_DATA_WIDTH-1:0] lut_v_in,
  input  logic [RANGE_WIDTH-1:0]    UU,
  input  logic [RANGE_WIDTH-1:0]    VV,
  input  logic [SYMBOL_WIDTH-1:0]   in_symbol,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RANGE_WIDTH-1:0]    out_low_add,
  output logic [RANGE_WIDTH-1:0]    out_range,
  output logic [D_WIDTH-1:0]        out_d
);

  logic [RANGE_WIDTH-1:0] range_reg;
  logic [7:0]             r8;
  logic [RANGE_WIDTH-1:0] u_val;
  logic [RANGE_WIDTH-1:0] v_val;
  logic [RANGE_WIDTH-1:0] vs_prod;
  logic [RANGE_WIDTH-1:0] new_r;
  logic [RANGE_WIDTH-1:0] low_add;
  logic [RANGE_WIDTH-1:0] norm_r;
  logic [D_WIDTH-1:0]     d_cnt;
  logic                   accept;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign r8       = range_reg[RANGE_WIDTH-1 -: 8];
  assign vs_prod  = scale_prod(r8, VV);

  always_comb begin
    u_val   = scale_prod(r8, UU) + lut_u_in;
    v_val   = vs_prod + lut_v_in;
    new_r   = '0;
    low_add = '0;
    unique case (1'b1)
      (~bool_n): begin
        v_val = vs_prod + EC_MIN_PROB;
        if (in_symbol[0]) begin
          new_r   = v_val;
          low_add = range_reg - v_val;
        end else begin
          new_r   = range_reg - v_val;
        end
      end
      (bool_n & COMP_mux_1): begin
        new_r   = u_val - v_val;
        low_add = range_reg - u_val;
      end
      (bool_n & ~COMP_mux_1): begin
        new_r   = range_reg - v_val;
      end
      default: ;
    endcase
  end

  stage_2_lzc #(
    .W  (RANGE_WIDTH),
    .DW (D_WIDTH)
  ) u_lzc (
    .din (new_r),
    .cnt (d_cnt)
  );

  // shift by RANGE_WIDTH on zero input yields zero range
  assign norm_r = new_r << d_cnt;

  always_ff @(posedge clk_stage_2) begin
    if (reset_stage_2) begin
      range_reg   <= RANGE_RESET;
      out_valid   <= 1'b0;
      out_low_add <= '0;
      out_range   <= RANGE_RESET;
      out_d       <= '0;
    end else if (accept) begin
      range_reg   <= norm_r;
      out_valid   <= 1'b1;
      out_low_add <= low_add;
      out_range   <= norm_r;
      out_d       <= d_cnt;
    end else begin
      out_valid   <= out_valid & ~out_ready;
    end
  end

endmodule
